rand_pick: RTL and testbench

RAND_PICK -- requirements
Module: rand_pick

---
 rtl/rand_pick.sv | 145 ++++++++++++++
 tb/tb_rand_pick.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rand_pick.sv
// rand_pick: draws a value in 0..RANGE-1 from an upstream LFSR byte by mask-and-reject,
// with a fold-down fallback after MAX_TRIES rejects. Optional no-repeat rule: RAND_PICK_NO_REPEAT_EN.
module rand_pick #(
  parameter int RANGE     = 6,
  parameter int W         = 3,
  parameter int MAX_TRIES = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [7:0]   lfsr_i,
  output logic         lfsr_en_o,
  input  logic         req_i,
  input  logic         ack_i,
  output logic [W-1:0] val_o,
  output logic         valid_o,
  output logic         busy_o
);

  // state  | meaning
  // IDLE   | waiting for req_i
  // STEP   | advance the upstream LFSR for one cycle
  // SAMPLE | mask the new LFSR byte, accept / reject / fall back
  // DONE   | val_o valid, waiting for ack_i
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STEP   = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam int         CW       = (RANGE <= 1) ? 1 : $clog2(RANGE);
  localparam logic [8:0] MASK_9   = 9'((1 << CW) - 1);
  localparam logic [8:0] RANGE_9  = 9'(RANGE);
  localparam logic [7:0] LAST_TRY = 8'(MAX_TRIES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_tries;
  logic [W-1:0] r_val;

  logic [8:0]  w_cand;
  logic        w_in_range;
  logic [8:0]  w_fold;
  logic [8:0]  w_fb;
  logic        w_accept;
  logic [8:0]  w_pick;
  logic        w_last_try;
  logic        w_clr_tries;
  logic        w_inc_tries;
  logic        w_load;

  // The mask keeps every candidate below 2*RANGE, so one subtraction folds it into range.
  assign w_cand     = {1'b0, lfsr_i} & MASK_9;
  assign w_in_range = (w_cand < RANGE_9);
  assign w_fold     = w_in_range ? w_cand : (w_cand - RANGE_9);
  assign w_last_try = (r_tries == LAST_TRY);

`ifdef RAND_PICK_NO_REPEAT_EN
  logic       r_last_vld;
  logic [8:0] r_last;
  logic       w_hit_last;
  logic       w_fb_bump;
  logic [8:0] w_fold_inc;

  assign w_hit_last = r_last_vld && (w_cand == r_last);
  assign w_accept   = w_in_range && !w_hit_last;
  assign w_fb_bump  = r_last_vld && (w_fold == r_last);
  assign w_fold_inc = w_fold + 9'd1;
  assign w_fb       = w_fb_bump ? ((w_fold_inc == RANGE_9) ? 9'd0 : w_fold_inc) : w_fold;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_last_vld <= 1'b0;
      r_last     <= '0;
    end else if (w_load) begin
      r_last_vld <= 1'b1;
      r_last     <= w_pick;
    end
  end
`else
  assign w_accept = w_in_range;
  assign w_fb     = w_fold;
`endif

  assign w_pick = w_accept ? w_cand : w_fb;

  always_comb begin
    w_state_nxt = r_state;
    w_clr_tries = 1'b0;
    w_inc_tries = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_i) begin
          w_state_nxt = S_STEP;
          w_clr_tries = 1'b1;
        end
      end
      S_STEP: begin
        w_state_nxt = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (w_accept || w_last_try) begin
          w_load      = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_inc_tries = 1'b1;
          w_state_nxt = S_STEP;
        end
      end
      S_DONE: begin
        if (ack_i) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_tries <= '0;
      r_val   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_clr_tries) begin
        r_tries <= '0;
      end else if (w_inc_tries) begin
        r_tries <= r_tries + 8'd1;
      end
      if (w_load) begin
        r_val <= W'(w_pick);
      end
    end
  end

  assign lfsr_en_o = (r_state == S_STEP);
  assign busy_o    = (r_state == S_STEP) || (r_state == S_SAMPLE);
  assign valid_o   = (r_state == S_DONE);
  assign val_o     = r_val;

endmodule

// File: tb/tb_rand_pick.sv
// tb_rand_pick: directed and randomized picks against a try-by-try reference model.
module tb_rand_pick;

  localparam int RANGE     = 6;
  localparam int W         = 3;
  localparam int MAX_TRIES = 4;
`ifdef RAND_PICK_NO_REPEAT_EN
  localparam bit NOREP = 1'b1;
`else
  localparam bit NOREP = 1'b0;
`endif

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [7:0]   lfsr_i;
  logic         lfsr_en_o;
  logic         req_i;
  logic         ack_i;
  logic [W-1:0] val_o;
  logic         valid_o;
  logic         busy_o;

  rand_pick #(.RANGE(RANGE), .W(W), .MAX_TRIES(MAX_TRIES)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .lfsr_i   (lfsr_i),
    .lfsr_en_o(lfsr_en_o),
    .req_i    (req_i),
    .ack_i    (ack_i),
    .val_o    (val_o),
    .valid_o  (valid_o),
    .busy_o   (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  int q_bytes[$];
  bit m_last_v = 1'b0;
  int m_last   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Walks the pending LFSR bytes one try at a time, the way the rules read.
  function automatic void model_pick(output int tries, output int val);
    int span;
    int c;
    int f;
    span = 1;
    while (span < RANGE) span = span * 2;
    tries = MAX_TRIES;
    val   = 0;
    for (int t = 1; t <= MAX_TRIES; t++) begin
      c = q_bytes[t-1] % span;
      if (c < RANGE && !(NOREP && m_last_v && c == m_last)) begin
        tries = t;
        val   = c;
        return;
      end
      if (t == MAX_TRIES) begin
        f = (c < RANGE) ? c : c - RANGE;
        if (NOREP && m_last_v && f == m_last) f = (f + 1) % RANGE;
        tries = t;
        val   = f;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Fill the byte queue up to MAX_TRIES entries with random bytes.
  task automatic pad_queue();
    while (q_bytes.size() < MAX_TRIES) q_bytes.push_back(int'($urandom_range(0, 255)));
  endtask

  task automatic run_pick(input string tag, output int got_edges);
    int  exp_tries;
    int  exp_val;
    int  pulses;
    int  edges;
    bit  pending;
    bit  done;
    pad_queue();
    model_pick(exp_tries, exp_val);
    pulses  = 0;
    edges   = 0;
    pending = 1'b0;
    done    = 1'b0;
    req_i   = 1'b1;
    while (!done && edges < 4 * MAX_TRIES + 10) begin
      tick();
      req_i = 1'b0;
      edges++;
      if (pending) begin
        lfsr_i  = 8'(q_bytes.pop_front());
        pending = 1'b0;
      end
      if (valid_o) begin
        done = 1'b1;
      end else begin
        check({tag, ".busy"}, busy_o, 1);
        if (lfsr_en_o) begin
          pulses++;
          pending = 1'b1;
        end
      end
    end
    if (!done) check({tag, ".timeout"}, 0, 1);
    check({tag, ".pulses"}, pulses, exp_tries);
    check({tag, ".latency"}, edges, 1 + 2 * exp_tries);
    check({tag, ".val"}, val_o, exp_val);
    check({tag, ".en_in_done"}, lfsr_en_o, 0);
    m_last_v  = 1'b1;
    m_last    = exp_val;
    got_edges = edges;
    q_bytes.delete();
  endtask

  task automatic do_ack(input string tag);
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
    check({tag, ".ack_valid"}, valid_o, 0);
    check({tag, ".ack_busy"}, busy_o, 0);
  endtask

  initial begin
    int e;
    logic [W-1:0] held;
    rst_i  = 1'b1;
    req_i  = 1'b0;
    ack_i  = 1'b0;
    lfsr_i = 8'h00;
    tick();
    tick();
    check("rst.val", val_o, 0);
    check("rst.valid", valid_o, 0);
    check("rst.busy", busy_o, 0);
    check("rst.en", lfsr_en_o, 0);
    req_i = 1'b1;
    tick();
    check("rst_prio.busy", busy_o, 0);
    rst_i = 1'b0;
    req_i = 1'b0;
    tick();

    q_bytes = '{8'h03};
    run_pick("single", e);
    check("single.val3", val_o, 3);
    check("single.edges3", e, 3);
    do_ack("single");

    q_bytes = '{8'h07, 8'h0E, 8'h02};
    run_pick("two_rej", e);
    check("two_rej.val2", val_o, 2);
    check("two_rej.edges7", e, 7);
    do_ack("two_rej");

    q_bytes = '{8'h07, 8'h07, 8'h07, 8'h07};
    run_pick("fallback", e);
    check("fallback.val1", val_o, 1);
    do_ack("fallback");

    q_bytes = '{8'h03};
    run_pick("rep_a", e);
    do_ack("rep_a");
    q_bytes = '{8'h03, 8'h05};
    run_pick("rep_b", e);
    check("rep_b.val", val_o, NOREP ? 5 : 3);
    do_ack("rep_b");

    // Reset in the second SAMPLE, after one reject.
    lfsr_i = 8'h07;
    req_i  = 1'b1;
    tick();
    req_i = 1'b0;
    tick();
    tick();
    tick();
    check("midrst.busy_pre", busy_o, 1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("midrst.val", val_o, 0);
    check("midrst.valid", valid_o, 0);
    check("midrst.busy", busy_o, 0);
    check("midrst.en", lfsr_en_o, 0);
    m_last_v = 1'b0;
    tick();
    check("midrst.idle", busy_o, 0);
    q_bytes = '{8'h07, 8'h07, 8'h07, 8'h07};
    run_pick("post_rst", e);
    check("post_rst.val1", val_o, 1);

    held = val_o;
    for (int i = 0; i < 10; i++) begin
      req_i = (i % 3 == 0);
      tick();
      check("hold.valid", valid_o, 1);
      check("hold.val", val_o, held);
      check("hold.en", lfsr_en_o, 0);
    end
    req_i = 1'b1;
    ack_i = 1'b1;
    tick();
    req_i = 1'b0;
    ack_i = 1'b0;
    check("ackreq.valid", valid_o, 0);
    check("ackreq.busy", busy_o, 0);
    tick();
    check("ackreq.idle", busy_o, 0);
    check("ackreq.idle_en", lfsr_en_o, 0);

    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < MAX_TRIES; k++) begin
        if ($urandom_range(0, 2) == 0) q_bytes.push_back(int'(8'hF6) + int'($urandom_range(0, 1)));
        else q_bytes.push_back(int'($urandom_range(0, 255)));
      end
      run_pick("rnd", e);
      for (int w = 0; w < int'($urandom_range(0, 3)); w++) begin
        tick();
        check("rnd.wait_valid", valid_o, 1);
      end
      do_ack("rnd");
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
